// File: rtl/vector_reduce_pkg.sv
// Shared constants and elaboration-time helpers for the vector_reduce block.
// Width derivations live here so the top, the tree stage and benches agree.
package vector_reduce_pkg;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    // Wide enough that no sum of DIM*MAX_BEATS elements can overflow.
    function automatic int unsigned res_width(input int unsigned w_u,
                                              input int unsigned dim,
                                              input int unsigned max_beats);
        return w_u + clog2(dim * max_beats);
    endfunction

    function automatic int unsigned tree_depth(input int unsigned dim);
        return clog2(dim);
    endfunction

    function automatic int unsigned beat_width(input int unsigned max_beats);
        return clog2(max_beats + 1);
    endfunction

    // Number of lanes still alive after 'level' pairwise tree stages.
    function automatic int unsigned lanes_at(input int unsigned dim,
                                             input int unsigned level);
        int unsigned n = dim;
        for (int unsigned i = 0; i < level; i++) n = (n + 1) / 2;
        return n;
    endfunction

endpackage

// File: rtl/vector_reduce_reduce_stage.sv
// One registered level of the adder tree: adds lanes pairwise and carries
// the valid/last sideband alongside; an odd trailing lane passes through.
module reduce_stage #(
    parameter int unsigned N_IN = 2,
    parameter int unsigned W = 8,
    localparam int unsigned N_OUT = (N_IN + 1) / 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [N_IN*W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic [N_OUT*W-1:0] out_data,
    output logic               out_valid,
    output logic               out_last
);

    logic [N_OUT*W-1:0] pair_sum_c;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        if (2 * j + 1 < N_IN) begin : g_add
            assign pair_sum_c[j*W +: W] = in_data[2*j*W +: W] + in_data[(2*j+1)*W +: W];
        end else begin : g_pass
            assign pair_sum_c[j*W +: W] = in_data[2*j*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_data  <= pair_sum_c;
            out_valid <= in_valid;
            out_last  <= in_last;
        end
    end

endmodule

// File: rtl/vector_reduce.sv
// Sums every element of a multi-beat vector: per-beat adder tree, then a
// beat accumulator, then a held output register with valid/ready handshake.
module vector_reduce
    import vector_reduce_pkg::*;
#(
    parameter int unsigned DIM       = 4,
    parameter int unsigned W_U       = 32,
    parameter int unsigned MAX_BEATS = 4,
    parameter bit          SIGNED    = 1'b0,
    localparam int unsigned RES_WIDTH  = res_width(W_U, DIM, MAX_BEATS),
    localparam int unsigned BEAT_WIDTH = beat_width(MAX_BEATS)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DIM*W_U-1:0]    u,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [RES_WIDTH-1:0]  sum,
    output logic [BEAT_WIDTH-1:0] out_beats,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int unsigned D  = tree_depth(DIM);
    localparam int unsigned RW = RES_WIDTH;
    localparam int unsigned BW = BEAT_WIDTH;

    logic stall;
    logic take;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign take     = in_valid && in_ready;

    // Widen every lane to the result width before any addition.
    logic [DIM*RW-1:0] lanes_ext;

    for (genvar i = 0; i < DIM; i++) begin : g_ext
        if (SIGNED) begin : g_sext
            assign lanes_ext[i*RW +: RW] = RW'($signed(u[i*W_U +: W_U]));
        end else begin : g_zext
            assign lanes_ext[i*RW +: RW] = RW'(u[i*W_U +: W_U]);
        end
    end

    logic [RW-1:0] tree_data;
    logic          tree_valid;
    logic          tree_last;

    if (D == 0) begin : g_flat
        assign tree_data  = lanes_ext;
        assign tree_valid = take;
        assign tree_last  = in_last;
    end else begin : g_tree
        for (genvar l = 0; l < D; l++) begin : g_lvl
            localparam int unsigned N_IN  = lanes_at(DIM, l);
            localparam int unsigned N_OUT = lanes_at(DIM, l + 1);

            logic [N_IN*RW-1:0]  d_in;
            logic [N_OUT*RW-1:0] d_out;
            logic                v_in;
            logic                l_in;
            logic                v_out;
            logic                l_out;

            if (l == 0) begin : g_head
                assign d_in = lanes_ext;
                assign v_in = take;
                assign l_in = in_last;
            end else begin : g_link
                assign d_in = g_lvl[l-1].d_out;
                assign v_in = g_lvl[l-1].v_out;
                assign l_in = g_lvl[l-1].l_out;
            end

            reduce_stage #(
                .N_IN(N_IN),
                .W   (RW)
            ) u_stage (
                .clk      (Clock),
                .rst      (Reset),
                .en       (!stall),
                .in_data  (d_in),
                .in_valid (v_in),
                .in_last  (l_in),
                .out_data (d_out),
                .out_valid(v_out),
                .out_last (l_out)
            );
        end

        assign tree_data  = g_lvl[D-1].d_out;
        assign tree_valid = g_lvl[D-1].v_out;
        assign tree_last  = g_lvl[D-1].l_out;
    end

    // Accumulator: 'done' marks a completed vector waiting to move to the output.
    logic [RW-1:0] acc;
    logic [BW-1:0] cnt;
    logic          done;
    logic          err;

    logic          fresh_c;
    logic [BW-1:0] cnt_nxt_c;
    logic          at_max_c;

    always_comb begin
        fresh_c   = done || (cnt == '0);
        cnt_nxt_c = fresh_c ? BW'(1) : cnt + BW'(1);
        at_max_c  = (cnt_nxt_c == BW'(MAX_BEATS));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc  <= '0;
            cnt  <= '0;
            done <= 1'b0;
            err  <= 1'b0;
        end else if (!stall) begin
            if (tree_valid) begin
                acc  <= fresh_c ? tree_data : acc + tree_data;
                cnt  <= cnt_nxt_c;
                done <= tree_last || at_max_c;
                err  <= at_max_c && !tree_last;
            end else if (done) begin
                done <= 1'b0;
                cnt  <= '0;
            end
        end
    end

    // Output register holds its payload for as long as the consumer stalls.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_valid <= 1'b0;
            sum       <= '0;
            out_beats <= '0;
            out_err   <= 1'b0;
        end else if (!stall) begin
            out_valid <= done;
            if (done) begin
                sum       <= acc;
                out_beats <= cnt;
                out_err   <= err;
            end
        end
    end

endmodule

// File: tb/tb_vector_reduce.sv
// Directed bench for vector_reduce (DIM=4, W_U=8, MAX_BEATS=4): an unsigned
// and a signed instance share stimulus; results are captured at handshake.
module tb_vector_reduce;

    typedef struct {
        logic [11:0] sum;
        logic [2:0]  beats;
        logic        err;
        int unsigned cyc;
    } res_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] u = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;

    logic        in_ready_u, out_valid_u, out_err_u;
    logic [11:0] sum_u;
    logic [2:0]  beats_u;
    logic        in_ready_s, out_valid_s, out_err_s;
    logic [11:0] sum_s;
    logic [2:0]  beats_s;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned cyc = 0;
    res_t        q_u[$];
    res_t        q_s[$];

    always #5 Clock = ~Clock;

    vector_reduce #(.DIM(4), .W_U(8), .MAX_BEATS(4), .SIGNED(1'b0)) dut_u (
        .Clock(Clock), .Reset(Reset), .u(u), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_u), .sum(sum_u), .out_beats(beats_u), .out_err(out_err_u),
        .out_valid(out_valid_u), .out_ready(out_ready)
    );

    vector_reduce #(.DIM(4), .W_U(8), .MAX_BEATS(4), .SIGNED(1'b1)) dut_s (
        .Clock(Clock), .Reset(Reset), .u(u), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready_s), .sum(sum_s), .out_beats(beats_s), .out_err(out_err_s),
        .out_valid(out_valid_s), .out_ready(out_ready)
    );

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (!Reset && out_valid_u && out_ready) q_u.push_back('{sum_u, beats_u, out_err_u, cyc});
        if (!Reset && out_valid_s && out_ready) q_s.push_back('{sum_s, beats_s, out_err_s, cyc});
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
        return {d, c, b, a};
    endfunction

    task automatic send_beat(input logic [31:0] lanes, input logic last);
        bit ok = 1'b0;
        u        = lanes;
        in_valid = 1'b1;
        in_last  = last;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (in_ready_u) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge Clock);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_eq("beat_accepted", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic wait_results(input int n);
        for (int i = 0; i < 200; i++) begin
            if (q_u.size() >= n && q_s.size() >= n) break;
            @(posedge Clock);
            #1;
        end
        check_eq("result_count", 32'(q_u.size()), 32'(n));
    endtask

    task automatic pop_check(input string tag, input int unsigned exp_sum,
                             input int unsigned exp_beats, input int unsigned exp_err);
        res_t r;
        check_eq({tag, "_present"}, 32'(q_u.size() > 0), 32'd1);
        if (q_u.size() > 0) begin
            r = q_u.pop_front();
            check_eq({tag, "_sum"}, 32'(r.sum), exp_sum);
            check_eq({tag, "_beats"}, 32'(r.beats), exp_beats);
            check_eq({tag, "_err"}, 32'(r.err), exp_err);
        end
        if (q_s.size() > 0) void'(q_s.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin
        int unsigned lat;
        int unsigned c0, c1, c2;
        logic [11:0] held;
        res_t        rs;

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_eq("rst_out_valid", 32'(out_valid_u), 32'd0);
        check_eq("rst_sum", 32'(sum_u), 32'd0);
        check_eq("rst_beats", 32'(beats_u), 32'd0);
        check_eq("rst_err", 32'(out_err_u), 32'd0);
        check_eq("rst_in_ready_u", 32'(in_ready_u), 32'd1);
        check_eq("rst_in_ready_s", 32'(in_ready_s), 32'd1);
        @(posedge Clock);
        #1 Reset = 1'b0;

        // Single beat and its latency
        send_beat(mk(8'd1, 8'd2, 8'd3, 8'd4), 1'b1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clock);
            #1;
            lat++;
            if (out_valid_u) break;
        end
        check_eq("single_latency", lat, 32'd3);
        wait_results(1);
        pop_check("single", 10, 1, 0);

        // Four full-scale beats, no overflow
        for (int k = 0; k < 4; k++) send_beat(mk(8'd255, 8'd255, 8'd255, 8'd255), k == 3);
        wait_results(1);
        pop_check("max", 4080, 4, 0);

        // Mixed-sign lanes: signed and unsigned interpretations
        send_beat(mk(8'hFF, 8'hFE, 8'h03, 8'h80), 1'b1);
        wait_results(1);
        rs = q_s.pop_front();
        check_eq("signed_sum", 32'(rs.sum), 32'hF80);
        check_eq("signed_beats", 32'(rs.beats), 32'd1);
        check_eq("signed_err", 32'(rs.err), 32'd0);
        pop_check("mixed_unsigned", 640, 1, 0);

        // Bubbles between beats carry garbage that must be ignored
        send_beat(mk(8'd10, 8'd20, 8'd30, 8'd40), 1'b0);
        u = '1;
        in_last = 1'b1;
        idle(3);
        in_last = 1'b0;
        send_beat(mk(8'd1, 8'd1, 8'd1, 8'd1), 1'b1);
        wait_results(1);
        pop_check("bubble", 104, 2, 0);

        // Back-to-back single-beat vectors, one result per cycle
        for (int k = 1; k <= 3; k++) send_beat(mk(8'(k), 8'd0, 8'd0, 8'd0), 1'b1);
        wait_results(3);
        if (q_u.size() >= 3) begin
            c0 = q_u[0].cyc;
            c1 = q_u[1].cyc;
            c2 = q_u[2].cyc;
            check_eq("tput_gap1", c1 - c0, 32'd1);
            check_eq("tput_gap2", c2 - c1, 32'd1);
        end
        pop_check("tput1", 1, 1, 0);
        pop_check("tput2", 2, 1, 0);
        pop_check("tput3", 3, 1, 0);

        // Backpressure with vectors queued behind the held result
        out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 5; k++) send_beat(mk(8'(k), 8'(k), 8'(k), 8'(k)), 1'b1);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge Clock);
                    if (out_valid_u) break;
                end
                held = sum_u;
                repeat (5) @(negedge Clock);
                check_eq("stall_in_ready", 32'(in_ready_u), 32'd0);
                check_eq("stall_sum_stable", 32'(sum_u), 32'(held));
                check_eq("stall_first_sum", 32'(held), 32'd4);
                @(posedge Clock);
                #1 out_ready = 1'b1;
            end
        join
        wait_results(5);
        idle(10);
        check_eq("stall_no_dup", 32'(q_u.size()), 32'd5);
        for (int k = 1; k <= 5; k++) pop_check("stall_order", 4 * k, 1, 0);

        // Reset in the middle of a vector discards it
        send_beat(mk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0);
        send_beat(mk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0);
        Reset = 1'b1;
        @(posedge Clock);
        #1 Reset = 1'b0;
        idle(8);
        check_eq("midrst_out_valid", 32'(out_valid_u), 32'd0);
        check_eq("midrst_no_result", 32'(q_u.size()), 32'd0);
        send_beat(mk(8'd2, 8'd2, 8'd2, 8'd2), 1'b1);
        wait_results(1);
        pop_check("after_rst", 8, 1, 0);

        // Truncation at MAX_BEATS; the fifth beat opens a new vector
        for (int k = 0; k < 5; k++) send_beat(mk(8'd1, 8'd1, 8'd1, 8'd1), 1'b0);
        send_beat(mk(8'd2, 8'd2, 8'd2, 8'd2), 1'b1);
        wait_results(2);
        pop_check("trunc", 16, 4, 1);
        pop_check("after_trunc", 12, 2, 0);
        idle(5);
        check_eq("no_extra", 32'(q_u.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vector_reduce.md
VECTOR_REDUCE -- requirements
Module: vector_reduce

Interface
REQ-001 SHALL have parameter DIM, default 4, giving the number of lanes (elements) per input beat; DIM >= 1.
REQ-002 SHALL have parameter W_U, default 32, giving the element width in bits.
REQ-003 SHALL have parameter MAX_BEATS, default 4, giving the maximum number of beats per vector; MAX_BEATS >= 1.
REQ-004 SHALL have parameter SIGNED, default 0, where 0 means elements are unsigned and 1 means two's-complement.
REQ-005 SHALL derive the local constant RES_WIDTH = W_U + clog2(DIM*MAX_BEATS) and the local constant D = clog2(DIM), the number of tree stages.
REQ-006 SHALL have port Clock: input, 1 bit, the only clock, rising-edge.
REQ-007 SHALL have port Reset: input, 1 bit, synchronous, active-high.
REQ-008 SHALL have port u: input, DIM*W_U bits; lane i occupies bits [W_U*i +: W_U].
REQ-009 SHALL have ports in_valid (input, 1), in_last (input, 1; marks the final beat of a vector) and in_ready (output, 1).
REQ-010 SHALL have port sum: output, RES_WIDTH bits, holding the vector total.
REQ-011 SHALL have port out_beats: output, clog2(MAX_BEATS+1) bits, giving the number of beats summed.
REQ-012 SHALL have ports out_err (output, 1; vector was truncated), out_valid (output, 1) and out_ready (input, 1).

Function
REQ-013 SHALL accept a beat when in_valid && in_ready are both high on a rising edge.
REQ-014 SHALL sign-extend (SIGNED=1) or zero-extend (SIGNED=0) every lane to RES_WIDTH before any addition; no intermediate sum may overflow.
REQ-015 SHALL reduce the DIM lanes through a binary adder tree with D registered stages; an odd lane count pads the missing operand with 0; DIM=1 gives zero stages.
REQ-016 SHALL carry a valid bit and a last bit alongside the data through every tree stage.
REQ-017 SHALL accumulate the tree outputs in one accumulator register; the first beat of a vector loads the value and later beats add to it.
REQ-018 SHALL count accepted beats per vector; if the count reaches MAX_BEATS without in_last, that beat is treated as last and out_err is set for the vector.
REQ-019 SHALL register the final total into sum, out_beats and out_err, and assert out_valid, D+1 cycles after the last beat is accepted, when there is no backpressure.
REQ-020 SHALL keep sum, out_beats and out_err stable while out_valid && !out_ready.
REQ-021 SHALL define a stall condition stall = out_valid && !out_ready.
REQ-022 SHALL freeze all tree stages, the accumulator and the beat counter while stall is high.
REQ-023 SHALL drive in_ready = !stall combinationally from out_valid and out_ready.
REQ-024 SHALL accept a new vector's first beat in the cycle after the previous vector's last beat is accepted, and sustain one result per cycle for single-beat vectors.
REQ-025 SHALL deassert out_valid after a handshake unless a new result is produced in the same cycle.
REQ-026 SHALL drop beats presented while in_valid is low (bubbles) without disturbing the accumulation.

Reset
REQ-027 SHALL, when Reset is high on a rising edge, clear to 0 every pipeline valid bit, the accumulator, the beat counter, out_valid, sum, out_beats and out_err; in_ready is 1 after reset.
REQ-028 SHALL discard any partially accumulated vector on Reset asserted mid-vector; the first beat accepted after reset starts a new vector.
REQ-029 SHALL give Reset priority over any simultaneous input or output handshake.

Structure
REQ-030 SHALL place clog2, the RES_WIDTH and D derivations and the beat-count width function in the shared package vector_reduce_pkg.
REQ-031 SHALL implement one tree level as the sub-module reduce_stage (pairwise add, valid/last pipeline, stall enable), instantiated D times through a generate loop.

Verification (DIM=4, W_U=8, MAX_BEATS=4, RES_WIDTH=12)
REQ-032 SHALL check that unsigned single beat {1,2,3,4} with last gives sum=10, out_beats=1, out_err=0, out_valid 3 cycles after acceptance.
REQ-033 SHALL check that 4 beats of all lanes 255, last on beat 4, give sum=4080 with no overflow and out_beats=4.
REQ-034 SHALL check that SIGNED=1 beat {-1,-2,3,-128} gives sum=-128 (12'hF80).
REQ-035 SHALL check that with out_ready low for 5 cycles and vectors queued, in_ready drops, sum is held stable, and all results emerge in order with none lost or duplicated.
REQ-036 SHALL check that Reset asserted after 2 beats of {1,1,1,1} gives out_valid=0, and that a following single beat {2,2,2,2} with last gives sum=8.
REQ-037 SHALL check that 5 beats of {1,1,1,1} with no in_last give sum=16, out_beats=4, out_err=1, and that the 5th beat starts a new vector.
